// File: rtl/seg_scan_drv_pkg.sv
// Shared constants for the 7-segment scan driver: segment encodings and FSM states.
package seg_scan_drv_pkg;

  // Active-low a..g in bits 7..1, dp_n in bit 0; index 0 is the last entry.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] ST_SHIFT = 2'd0;
  localparam logic [1:0] ST_LATCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  function automatic logic [7:0] seg_of(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction

endpackage

// File: rtl/seg_scan_drv_if.sv
// Upstream valid/ready image port of the scan driver.
interface seg_scan_drv_if #(parameter int DIGITS = 8);
  logic [4*DIGITS-1:0] val;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank;
  logic                lzs;
  logic                load;
  logic                ready;

  modport master (output val, dp, blank, lzs, load, input ready);
  modport slave  (input val, dp, blank, lzs, load, output ready);
endinterface

// File: rtl/seg_scan_drv_ser16.sv
// 16-bit LSB-first serialiser: ds changes at the start of each bit-period,
// shclk is high for the second half of it. ds holds its last bit when idle.
module seg_ser16 #(
  parameter int DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] word,
  output logic        busy,
  output logic        done,
  output logic        ds,
  output logic        shclk
);
  localparam int CW = $clog2(2*DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(2*DIV-1);
  localparam logic [CW-1:0] CNT_HI   = CW'(DIV);

  logic          busy_q, busy_d;
  logic          ds_q, ds_d;
  logic          shclk_q, shclk_d;
  logic [14:0]   sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    bit_q, bit_d;

  assign busy  = busy_q;
  assign ds    = ds_q;
  assign shclk = shclk_q;
  assign done  = busy_q && (cnt_q == CNT_LAST) && (bit_q == 4'd15);

  always_comb begin
    busy_d  = busy_q;
    ds_d    = ds_q;
    shclk_d = shclk_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    cnt_inc = cnt_q + 1'b1;
    if (start && !busy_q) begin
      busy_d  = 1'b1;
      ds_d    = word[0];
      sh_d    = word[15:1];
      cnt_d   = '0;
      bit_d   = 4'd0;
      shclk_d = 1'b0;
    end else if (busy_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        shclk_d = 1'b0;
        if (bit_q == 4'd15) begin
          busy_d = 1'b0;
        end else begin
          bit_d = bit_q + 4'd1;
          ds_d  = sh_q[0];
          sh_d  = {1'b0, sh_q[14:1]};
        end
      end else begin
        cnt_d   = cnt_inc;
        shclk_d = (cnt_inc >= CNT_HI);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      ds_q    <= 1'b0;
      shclk_q <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      bit_q   <= 4'd0;
    end else begin
      busy_q  <= busy_d;
      ds_q    <= ds_d;
      shclk_q <= shclk_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end
endmodule

// File: rtl/seg_scan_drv.sv
// Multiplexed 7-segment scan driver for a daisy-chained 595 board: image capture,
// leading-zero suppression, SHIFT/LATCH/HOLD scan and PWM brightness on oe_n.
module seg_scan_drv #(
  parameter int DIGITS    = 8,
  parameter int DIV       = 2,
  parameter int HOLD_BITS = 16,
  parameter int BRIGHT_W  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_scan_drv_if.slave       up,
  input  logic [BRIGHT_W-1:0] bright,
  output logic                ds,
  output logic                shclk,
  output logic                stclk,
  output logic                oe_n,
  output logic                frame
);
  import seg_scan_drv_pkg::*;

  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int HW = $clog2(HOLD_BITS);
  localparam int CW = $clog2(2*DIV);
  localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS-1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_BITS-1);
  localparam logic [CW-1:0] PC_LAST   = CW'(2*DIV-1);

  logic [1:0]          st_q, st_d;
  logic [DW-1:0]       dig_q, dig_d, kdig;
  logic [CW-1:0]       pc_q, pc_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [BRIGHT_W-1:0] bright_q, bright_d;
  logic                stclk_q, stclk_d, oe_n_q, oe_n_d, frame_q, frame_d;
  logic                pend_full_q, pend_full_d, pend_lzs_q, pend_lzs_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d, src_val;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, pend_blank_q, pend_blank_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d, act_blk_q, act_blk_d;
  logic [DIGITS-1:0]   pend_mask, src_dp, src_blk;
  logic                lzs_run, kick, xfer, cap, pc_last, hold_last;
  logic [3:0]          nib;
  logic [7:0]          seg, sel;
  logic [15:0]         word;
  logic                ser_busy, ser_done;

  assign up.ready = !pend_full_q;
  assign stclk    = stclk_q;
  assign oe_n     = oe_n_q;
  assign frame    = frame_q;

  // Leading zeros become blank, scanning down from the top digit; digit 0 always shows.
  always_comb begin
    lzs_run   = pend_lzs_q;
    pend_mask = pend_blank_q;
    for (int i = DIGITS-1; i >= 1; i--) begin
      if (lzs_run && pend_val_q[4*i +: 4] == 4'h0) pend_mask[i] = 1'b1;
      else lzs_run = 1'b0;
    end
  end

  // A new word is kicked on the last HOLD clk so SHIFT starts with no dead cycle;
  // straight out of reset the serialiser is idle and SHIFT kicks it itself.
  always_comb begin
    pc_last   = (pc_q == PC_LAST);
    hold_last = (st_q == ST_HOLD) && (hold_q == HOLD_LAST) && pc_last;
    kick      = ((st_q == ST_SHIFT) && !ser_busy) || hold_last;
    kdig      = (st_q == ST_HOLD) ? ((dig_q == DIG_LAST) ? '0 : dig_q + 1'b1) : dig_q;
    xfer      = kick && (kdig == '0);
    cap       = up.load && (!pend_full_q || xfer);
    src_val   = (xfer && pend_full_q) ? pend_val_q : act_val_q;
    src_dp    = (xfer && pend_full_q) ? pend_dp_q  : act_dp_q;
    src_blk   = (xfer && pend_full_q) ? pend_mask  : act_blk_q;
    nib       = src_val[4*int'(kdig) +: 4];
    seg       = src_blk[kdig] ? SEG_BLANK : seg_of(nib);
    seg[0]    = seg[0] & ~src_dp[kdig];
    sel       = 8'd1 << kdig;
    word      = {sel, seg};
  end

  always_comb begin
    st_d         = st_q;
    dig_d        = dig_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    bright_d     = bright_q;
    stclk_d      = stclk_q;
    oe_n_d       = oe_n_q;
    frame_d      = 1'b0;
    pend_full_d  = pend_full_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_lzs_d   = pend_lzs_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_blk_d    = act_blk_q;
    case (st_q)
      ST_SHIFT: if (ser_done) begin
        st_d    = ST_LATCH;
        pc_d    = '0;
        stclk_d = 1'b1;
      end
      ST_LATCH: if (pc_last) begin
        st_d     = ST_HOLD;
        pc_d     = '0;
        hold_d   = '0;
        stclk_d  = 1'b0;
        bright_d = bright;
        oe_n_d   = (bright == '0);
      end else begin
        pc_d = pc_q + 1'b1;
      end
      ST_HOLD: begin
        pc_d = pc_last ? '0 : pc_q + 1'b1;
        if (pc_last) hold_d = hold_q + 1'b1;
        oe_n_d = !(BRIGHT_W'(hold_d) < bright_q);
        if (hold_last) begin
          st_d    = ST_SHIFT;
          oe_n_d  = 1'b1;
          frame_d = (dig_q == DIG_LAST);
        end
      end
      default: st_d = ST_SHIFT;
    endcase
    if (kick) dig_d = kdig;
    if (xfer && pend_full_q) begin
      act_val_d = pend_val_q;
      act_dp_d  = pend_dp_q;
      act_blk_d = pend_mask;
    end
    if (xfer) pend_full_d = 1'b0;
    if (cap) begin
      pend_full_d  = 1'b1;
      pend_val_d   = up.val;
      pend_dp_d    = up.dp;
      pend_blank_d = up.blank;
      pend_lzs_d   = up.lzs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= ST_SHIFT;
      dig_q        <= '0;
      pc_q         <= '0;
      hold_q       <= '0;
      bright_q     <= '0;
      stclk_q      <= 1'b0;
      oe_n_q       <= 1'b1;
      frame_q      <= 1'b0;
      pend_full_q  <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_lzs_q   <= 1'b0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blk_q    <= '1;
    end else begin
      st_q         <= st_d;
      dig_q        <= dig_d;
      pc_q         <= pc_d;
      hold_q       <= hold_d;
      bright_q     <= bright_d;
      stclk_q      <= stclk_d;
      oe_n_q       <= oe_n_d;
      frame_q      <= frame_d;
      pend_full_q  <= pend_full_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_lzs_q   <= pend_lzs_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_blk_q    <= act_blk_d;
    end
  end

  seg_ser16 #(.DIV(DIV)) u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .start (kick),
    .word  (word),
    .busy  (ser_busy),
    .done  (ser_done),
    .ds    (ds),
    .shclk (shclk)
  );
endmodule

// File: tb/tb_seg_scan_drv.sv
// Scoreboard bench for seg_scan_drv: stimulus pushes the expected word and on-time
// of every digit scan; a pin-level monitor rebuilds words from ds/shclk/stclk.
module tb_seg_scan_drv;
  localparam int DIGITS     = 8;
  localparam int DIV        = 2;
  localparam int HOLD_BITS  = 16;
  localparam int BRIGHT_W   = 5;
  localparam int DIGIT_CLKS = (16 + 1 + HOLD_BITS) * 2 * DIV;
  localparam int FRAME_MAX  = DIGITS * DIGIT_CLKS + 200;

  typedef struct {
    logic [15:0] word;
    int          on;
  } exp_t;

  typedef struct {
    logic [4*DIGITS-1:0] val;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic                lzs;
  } img_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [BRIGHT_W-1:0] bright;
  logic ds, shclk, stclk, oe_n, frame;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  img_t act_m, pend_m, blank_img, nxt;
  bit   pend_full_m;

  seg_scan_drv_if #(.DIGITS(DIGITS)) up ();

  seg_scan_drv #(.DIGITS(DIGITS), .DIV(DIV), .HOLD_BITS(HOLD_BITS), .BRIGHT_W(BRIGHT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .up     (up),
    .bright (bright),
    .ds     (ds),
    .shclk  (shclk),
    .stclk  (stclk),
    .oe_n   (oe_n),
    .frame  (frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 8'h03; 4'h1: return 8'h9F; 4'h2: return 8'h25; 4'h3: return 8'h0D;
      4'h4: return 8'h99; 4'h5: return 8'h49; 4'h6: return 8'h41; 4'h7: return 8'h1F;
      4'h8: return 8'h01; 4'h9: return 8'h09; 4'hA: return 8'h11; 4'hB: return 8'hC1;
      4'hC: return 8'h63; 4'hD: return 8'h85; 4'hE: return 8'h61; default: return 8'h71;
    endcase
  endfunction

  // One frame of expectations: a digit is dark if blanked or above the highest
  // non-zero nibble when suppression is on.
  task automatic push_frame(input img_t im, input int br);
    int top;
    logic [7:0] seg;
    exp_t e;
    top = 0;
    for (int i = 0; i < DIGITS; i++) if (im.val[4*i +: 4] != 4'h0) top = i;
    for (int d = 0; d < DIGITS; d++) begin
      if (im.blank[d] || (im.lzs && d > top)) seg = 8'hFF;
      else seg = hex7(im.val[4*d +: 4]);
      if (im.dp[d]) seg[0] = 1'b0;
      e.word = {8'(1 << d), seg};
      e.on   = ((br > HOLD_BITS) ? HOLD_BITS : br) * 2 * DIV;
      q.push_back(e);
    end
  endtask

  task automatic do_load(input img_t im, input bit twice);
    @(negedge clk);
    chk("ready_before_load", {31'd0, up.ready}, {31'd0, !pend_full_m});
    up.val = im.val; up.dp = im.dp; up.blank = im.blank; up.lzs = im.lzs; up.load = 1'b1;
    @(negedge clk);
    up.load = 1'b0;
    pend_m = im;
    pend_full_m = 1'b1;
    chk("ready_after_load", {31'd0, up.ready}, 32'd0);
    if (twice) begin
      up.val = $urandom; up.dp = 8'($urandom); up.blank = 8'($urandom); up.load = 1'b1;
      @(negedge clk);
      up.load = 1'b0;
      chk("ready_second_load", {31'd0, up.ready}, 32'd0);
    end
    up.val = $urandom; up.dp = 8'($urandom); up.blank = 8'($urandom); up.lzs = 1'($urandom);
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (!frame && n < FRAME_MAX) begin
      @(negedge clk);
      n++;
    end
    chk("frame_seen", {31'd0, frame}, 32'd1);
  endtask

  task automatic start_frame(input int br);
    chk("ready_at_frame", {31'd0, up.ready}, 32'd1);
    if (pend_full_m) begin
      act_m = pend_m;
      pend_full_m = 1'b0;
    end
    bright = BRIGHT_W'(br);
    push_frame(act_m, br);
  endtask

  function automatic img_t rand_img();
    img_t im;
    im.val   = $urandom >> $urandom_range(0, 28);
    im.dp    = 8'($urandom);
    im.blank = 8'($urandom) & 8'($urandom);
    im.lzs   = 1'($urandom);
    return im;
  endfunction

  initial begin : mon
    logic [15:0] w;
    logic [7:0]  lsel;
    int nb, oc, pon;
    bit bad, pst, psh, pfr;
    exp_t e;
    w = '0; lsel = '0; nb = 0; oc = 0; pon = -1; bad = 0; pst = 0; psh = 0; pfr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nb = 0; oc = 0; pon = -1; bad = 0; pst = 0; psh = 0; pfr = 0; lsel = '0;
      end else begin
        if (shclk && !psh) begin
          w = {ds, w[15:1]};
          nb++;
        end
        if (!oe_n) begin
          oc++;
          if (shclk || stclk) bad = 1;
        end
        if (stclk && shclk) bad = 1;
        if (stclk && !pst) begin
          if (q.size() == 0) begin
            chk("word_unexpected", {16'd0, w}, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("word", {16'd0, w}, {16'd0, e.word});
            chk("bits_per_word", nb, 16);
            chk("no_ghost", {31'd0, bad}, 32'd0);
            if (pon >= 0) chk("oe_on_clks", oc, pon);
            pon = e.on;
          end
          oc = 0; nb = 0; bad = 0; lsel = w[15:8];
        end
        if (frame && !pfr) chk("frame_after_last_digit", {24'd0, lsel}, 32'h80);
        if (pfr) chk("frame_width", {31'd0, frame}, 32'd0);
        psh = shclk; pst = stclk; pfr = frame;
      end
    end
  end

  initial begin
    blank_img.val = '0; blank_img.dp = '0; blank_img.blank = '1; blank_img.lzs = 1'b0;
    up.val = '0; up.dp = '0; up.blank = '0; up.lzs = 1'b0; up.load = 1'b0;
    bright = BRIGHT_W'(16);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ds", {31'd0, ds}, 32'd0);
    chk("rst_shclk", {31'd0, shclk}, 32'd0);
    chk("rst_stclk", {31'd0, stclk}, 32'd0);
    chk("rst_oe_n", {31'd0, oe_n}, 32'd1);
    chk("rst_ready", {31'd0, up.ready}, 32'd1);
    chk("rst_frame", {31'd0, frame}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    act_m = blank_img;
    pend_full_m = 1'b0;
    push_frame(act_m, 16);
    repeat (10) @(negedge clk);
    nxt.val = 32'h1234_5678; nxt.dp = '0; nxt.blank = '0; nxt.lzs = 1'b0;
    do_load(nxt, 1'b1);

    for (int f = 0; f < 8; f++) begin
      int br;
      bit ld;
      wait_frame();
      case (f)
        0: br = 4;
        1: br = 0;
        2: br = 16;
        3: br = 7;
        default: br = $urandom_range(0, 20);
      endcase
      start_frame(br);
      ld = 1'b1;
      case (f)
        0: begin nxt.val = 32'h42; nxt.dp = '0; nxt.blank = '0; nxt.lzs = 1'b1; end
        1: begin nxt.val = 32'h42; nxt.dp = '0; nxt.blank = '0; nxt.lzs = 1'b0; end
        2: begin nxt = rand_img(); nxt.dp = 8'h08; nxt.blank = 8'h08; end
        default: begin nxt = rand_img(); ld = 1'($urandom); end
      endcase
      repeat (20) @(negedge clk);
      if (ld) do_load(nxt, 1'b0);
    end

    // Reset in the middle of digit 5's shift.
    wait_frame();
    start_frame(9);
    repeat (5 * DIGIT_CLKS + 30) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ds", {31'd0, ds}, 32'd0);
    chk("midrst_shclk", {31'd0, shclk}, 32'd0);
    chk("midrst_stclk", {31'd0, stclk}, 32'd0);
    chk("midrst_oe_n", {31'd0, oe_n}, 32'd1);
    chk("midrst_ready", {31'd0, up.ready}, 32'd1);
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    act_m = blank_img;
    pend_full_m = 1'b0;
    push_frame(act_m, 9);
    repeat (10) @(negedge clk);
    do_load(rand_img(), 1'b0);
    wait_frame();
    start_frame(12);
    wait_frame();
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
